note_sequencer: RTL and testbench

Step sequencer that drives the note-duration counter and the tone generator. It holds a programmable pattern of up to STEPS notes. On `play` it walks the pattern: it emits the current note code and gate, produces the sample-rate `count_inc` ticks, and pulses `note_change` to restart the duration counter. It advances when `count_done` reports that a note period has elapsed. It sits between the control/keyboard front end and the noteCounter/oscillator datapath.

---
 rtl/note_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_note_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - pattern step sequencer driving the note-duration counter and tone generator
//
// Walks a programmable pattern of up to STEPS notes. Each step is
// {rest, len[1:0], note} and lasts len+1 note periods. A note period ends
// when the external duration counter raises count_done.
//
// Ports:
//   Clk, Reset          clock (rising edge), asynchronous active-low reset
//   wr_en/addr/data     pattern memory write port, usable in any state
//   play, stop          start from step 0 / abort (stop has priority)
//   loop_en, last_step  wrap-or-finish control, sampled when a step ends
//   count_done          duration counter elapsed (level)
//   count_inc           sample-rate tick to the duration counter
//   note_change         duration counter restart pulse
//   note_code, gate     current note and its sounding flag
//   step_idx, busy      current step, sequencer active
//   done                one-cycle pulse when a non-looping pattern ends
module note_sequencer #(
    parameter int STEPS      = 16,
    parameter int NOTE_W     = 8,
    parameter int SAMPLE_DIV = 1134,
    localparam int AW        = $clog2(STEPS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NOTE_W+2:0] wr_data,
    input  logic              play,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [AW-1:0]     last_step,
    input  logic              count_done,
    output logic              count_inc,
    output logic              note_change,
    output logic [NOTE_W-1:0] note_code,
    output logic              gate,
    output logic [AW-1:0]     step_idx,
    output logic              busy,
    output logic              done
);

    localparam int DW   = NOTE_W + 3;
    localparam int DIVW = $clog2(SAMPLE_DIV);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_START   = 3'd2,
        S_RUN     = 3'd3,
        S_ADVANCE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     mem_q [STEPS];
    logic [DW-1:0]     cur_q, cur_d;
    logic [AW-1:0]     step_q, step_d;
    logic [1:0]        rep_q, rep_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic              done_q, done_d;

    logic              cur_rest;
    logic [1:0]        cur_len;

    assign cur_rest = cur_q[DW-1];
    assign cur_len  = cur_q[NOTE_W+1:NOTE_W];

    // Pattern memory: writes are accepted in every state. A write to the
    // step being fetched lands on the same edge as the fetch, so the fetch
    // sees the old contents.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < STEPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop overrides every transition, including play.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (play) state_d = S_FETCH;
            S_FETCH:   state_d = S_START;
            S_START:   state_d = S_RUN;
            S_RUN: begin
                if (count_done) begin
                    state_d = (rep_q < cur_len) ? S_START : S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if ((step_q != last_step) || loop_en) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default:   state_d = S_IDLE;
        endcase
        if (stop) begin
            state_d = S_IDLE;
        end
    end

    // Datapath next-state; a stop cycle freezes everything so step_idx and
    // note_code keep their values and done is never raised.
    always_comb begin
        cur_d  = cur_q;
        step_d = step_q;
        rep_d  = rep_q;
        div_d  = div_q;
        done_d = 1'b0;
        if (!stop) begin
            case (state_q)
                S_IDLE: begin
                    if (play) begin
                        step_d = '0;
                        rep_d  = '0;
                    end
                end
                S_FETCH: cur_d = mem_q[step_q];
                S_START: div_d = '0;
                S_RUN: begin
                    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIVW'(1);
                    if (count_done && (rep_q < cur_len)) begin
                        rep_d = rep_q + 2'd1;
                    end
                end
                S_ADVANCE: begin
                    rep_d = '0;
                    // Modular increment: if last_step was lowered below the
                    // current index, the walk wraps through STEPS-1 to 0.
                    if (step_q != last_step) begin
                        step_d = step_q + AW'(1);
                    end else if (loop_en) begin
                        step_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cur_q  <= '0;
            step_q <= '0;
            rep_q  <= '0;
            div_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            step_q <= step_d;
            rep_q  <= rep_d;
            div_q  <= div_d;
            done_q <= done_d;
        end
    end

    // Outputs decode registered state only; done is registered so it
    // appears in the IDLE cycle that follows the final ADVANCE.
    always_comb begin
        note_change = (state_q == S_START);
        gate        = ((state_q == S_START) || (state_q == S_RUN)) && !cur_rest;
        count_inc   = (state_q == S_RUN) && (div_q == DIV_LAST);
        busy        = (state_q != S_IDLE);
    end

    assign note_code = cur_q[NOTE_W-1:0];
    assign step_idx  = step_q;
    assign done      = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench for note_sequencer
module tb_note_sequencer;

    localparam int STEPS      = 16;
    localparam int NOTE_W     = 8;
    localparam int SAMPLE_DIV = 4;
    localparam int AW         = 4;
    localparam int COUNT_MAX  = 3;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [NOTE_W+2:0] wr_data = '0;
    logic              play = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [AW-1:0]     last_step = '0;
    logic              count_done;
    logic              count_inc;
    logic              note_change;
    logic [NOTE_W-1:0] note_code;
    logic              gate;
    logic [AW-1:0]     step_idx;
    logic              busy;
    logic              done;

    int vectors = 0;
    int miscompares = 0;

    note_sequencer #(
        .STEPS(STEPS),
        .NOTE_W(NOTE_W),
        .SAMPLE_DIV(SAMPLE_DIV)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .play(play),
        .stop(stop),
        .loop_en(loop_en),
        .last_step(last_step),
        .count_done(count_done),
        .count_inc(count_inc),
        .note_change(note_change),
        .note_code(note_code),
        .gate(gate),
        .step_idx(step_idx),
        .busy(busy),
        .done(done)
    );

    always #5 Clk = ~Clk;

    // Duration counter model: restarted by note_change, saturates at COUNT_MAX.
    logic [1:0] dcnt;
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) dcnt <= 2'd0;
        else if (note_change) dcnt <= 2'd0;
        else if (count_inc && dcnt != 2'(COUNT_MAX)) dcnt <= dcnt + 2'd1;
    end
    assign count_done = (dcnt == 2'(COUNT_MAX));

    task automatic write_step(input int addr, input bit r, input int len, input int note);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = {r, 2'(len), 8'(note)};
        @(negedge Clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_play();
        play = 1'b1;
        @(negedge Clk);
        play = 1'b0;
    endtask

    task automatic wait_nc(input int want_idx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (note_change && step_idx == AW'(want_idx)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 Reset = 1'b0;
        repeat (3) @(negedge Clk);
        vectors++; if ({count_inc, note_change, gate, busy, done} !== 5'b0) begin miscompares++; $display("FAIL rst_ctrl: got %b, expected 00000", {count_inc, note_change, gate, busy, done}); end
        vectors++; if (note_code !== 8'h00 || step_idx !== 4'h0) begin miscompares++; $display("FAIL rst_data: got note %h idx %0d, expected 00 / 0", note_code, step_idx); end
        Reset = 1'b1;
        @(negedge Clk);
        vectors++; if (busy !== 1'b0 || note_change !== 1'b0) begin miscompares++; $display("FAIL rst_release: got busy %b nc %b, expected 0 0", busy, note_change); end
    endtask

    task automatic test_single_pass();
        logic [7:0] exp_notes [3];
        int nc, incs, dn, first_nc, first_inc;
        exp_notes[0] = 8'h10; exp_notes[1] = 8'h20; exp_notes[2] = 8'h30;
        write_step(0, 0, 0, 8'h10);
        write_step(1, 0, 0, 8'h20);
        write_step(2, 0, 0, 8'h30);
        last_step = 4'd2; loop_en = 1'b0;
        pulse_play();
        vectors++; if (busy !== 1'b1 || note_change !== 1'b0) begin miscompares++; $display("FAIL sp_fetch: got busy %b nc %b, expected 1 0", busy, note_change); end
        nc = 0; incs = 0; dn = 0; first_nc = -1; first_inc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge Clk);
            if (note_change) begin
                if (first_nc < 0) first_nc = i;
                if (nc > 0) begin
                    vectors++; if (incs != 3) begin miscompares++; $display("FAIL sp_incs_step%0d: got %0d, expected 3", nc - 1, incs); end
                end
                vectors++;
                if (nc < 3) begin
                    if (note_code !== exp_notes[nc]) begin miscompares++; $display("FAIL sp_note%0d: got %h, expected %h", nc, note_code, exp_notes[nc]); end
                end else begin
                    miscompares++; $display("FAIL sp_extra_note: got note_change #%0d, expected 3 only", nc + 1);
                end
                nc++; incs = 0;
            end
            if (count_inc) begin
                if (first_inc < 0) first_inc = i;
                incs++;
            end
            if (done) begin
                dn++;
                vectors++; if (incs != 3) begin miscompares++; $display("FAIL sp_incs_last: got %0d, expected 3", incs); end
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sp_done_busy: got %b, expected 0", busy); end
                break;
            end
        end
        vectors++; if (first_nc != 1) begin miscompares++; $display("FAIL sp_nc_latency: got %0d, expected 1", first_nc); end
        vectors++; if (first_inc != 5) begin miscompares++; $display("FAIL sp_inc_latency: got %0d, expected 5", first_inc); end
        vectors++; if (nc != 3) begin miscompares++; $display("FAIL sp_nc_count: got %0d, expected 3", nc); end
        vectors++; if (dn != 1) begin miscompares++; $display("FAIL sp_done_count: got %0d, expected 1", dn); end
        @(negedge Clk);
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL sp_after: got done %b busy %b, expected 0 0", done, busy); end
    endtask

    task automatic test_len_rest();
        int nc0, nc1, g0, g1, rises, dn;
        logic gprev;
        write_step(0, 0, 2, 8'h44);
        write_step(1, 1, 0, 8'h66);
        last_step = 4'd1; loop_en = 1'b0;
        pulse_play();
        nc0 = 0; nc1 = 0; g0 = 0; g1 = 0; rises = 0; dn = 0; gprev = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (note_change) begin
                if (step_idx == 4'd0) begin
                    nc0++;
                    vectors++; if (note_code !== 8'h44) begin miscompares++; $display("FAIL lr_note: got %h, expected 44", note_code); end
                end else begin
                    nc1++;
                end
            end
            if (gate && !gprev) rises++;
            gprev = gate;
            if (gate) begin
                if (step_idx == 4'd0) g0++; else g1++;
            end
            if (done) begin dn = 1; break; end
        end
        vectors++; if (nc0 != 3) begin miscompares++; $display("FAIL lr_nc_step0: got %0d, expected 3", nc0); end
        vectors++; if (nc1 != 1) begin miscompares++; $display("FAIL lr_nc_step1: got %0d, expected 1", nc1); end
        vectors++; if (g0 != 42) begin miscompares++; $display("FAIL lr_gate_step0: got %0d cycles, expected 42", g0); end
        vectors++; if (g1 != 0) begin miscompares++; $display("FAIL lr_gate_rest: got %0d cycles, expected 0", g1); end
        vectors++; if (rises != 1) begin miscompares++; $display("FAIL lr_gate_rises: got %0d, expected 1", rises); end
        vectors++; if (dn != 1) begin miscompares++; $display("FAIL lr_done: got %0d, expected 1", dn); end
    endtask

    task automatic test_loop();
        int nc, dn, nc_after, dn2;
        write_step(0, 0, 0, 8'h11);
        write_step(1, 0, 0, 8'h22);
        last_step = 4'd1; loop_en = 1'b1;
        pulse_play();
        nc = 0; dn = 0; nc_after = 0; dn2 = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            if (done) dn++;
            if (note_change) begin
                vectors++; if (step_idx !== AW'(nc % 2)) begin miscompares++; $display("FAIL lp_idx%0d: got %0d, expected %0d", nc, step_idx, nc % 2); end
                nc++;
                if (nc == 5) begin loop_en = 1'b0; break; end
            end
        end
        vectors++; if (nc != 5) begin miscompares++; $display("FAIL lp_nc_count: got %0d, expected 5", nc); end
        vectors++; if (dn != 0) begin miscompares++; $display("FAIL lp_done_while_looping: got %0d, expected 0", dn); end
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (note_change) begin
                nc_after++;
                vectors++; if (step_idx !== 4'd1) begin miscompares++; $display("FAIL lp_final_idx: got %0d, expected 1", step_idx); end
            end
            if (done) begin dn2 = 1; break; end
        end
        vectors++; if (nc_after != 1) begin miscompares++; $display("FAIL lp_tail_steps: got %0d, expected 1", nc_after); end
        vectors++; if (dn2 != 1) begin miscompares++; $display("FAIL lp_done: got %0d, expected 1", dn2); end
        vectors++; if (step_idx !== 4'd1 || busy !== 1'b0) begin miscompares++; $display("FAIL lp_end_state: got idx %0d busy %b, expected 1 0", step_idx, busy); end
    endtask

    task automatic test_stop_play();
        bit ok;
        int dn;
        play = 1'b1; stop = 1'b1;
        @(negedge Clk);
        play = 1'b0; stop = 1'b0;
        vectors++; if (busy !== 1'b0 || step_idx !== 4'd1) begin miscompares++; $display("FAIL sc_collision: got busy %b idx %0d, expected 0 1", busy, step_idx); end
        @(negedge Clk);
        vectors++; if (busy !== 1'b0 || note_change !== 1'b0) begin miscompares++; $display("FAIL sc_still_idle: got busy %b nc %b, expected 0 0", busy, note_change); end
        loop_en = 1'b0; last_step = 4'd1;
        pulse_play();
        wait_nc(1, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL sc_reach_step1: got timeout, expected note_change at step 1"); end
        repeat (3) @(negedge Clk);
        vectors++; if (gate !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL sc_running: got gate %b busy %b, expected 1 1", gate, busy); end
        stop = 1'b1;
        @(negedge Clk);
        stop = 1'b0;
        vectors++; if ({busy, gate, done, count_inc, note_change} !== 5'b0) begin miscompares++; $display("FAIL sc_stop_outputs: got %b, expected 00000", {busy, gate, done, count_inc, note_change}); end
        vectors++; if (step_idx !== 4'd1 || note_code !== 8'h22) begin miscompares++; $display("FAIL sc_stop_hold: got idx %0d note %h, expected 1 22", step_idx, note_code); end
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (done || busy) dn++;
        end
        vectors++; if (dn != 0) begin miscompares++; $display("FAIL sc_quiet: got %0d active cycles, expected 0", dn); end
    endtask

    task automatic test_write_fetch();
        bit ok, found;
        logic [AW-1:0] prev;
        write_step(0, 0, 0, 8'h11);
        write_step(1, 0, 0, 8'h22);
        last_step = 4'd1; loop_en = 1'b1;
        pulse_play();
        prev = step_idx;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (busy && step_idx == 4'd1 && prev == 4'd0) begin
                wr_en = 1'b1; wr_addr = 4'd1; wr_data = {1'b0, 2'd0, 8'h55};
                found = 1'b1;
                @(negedge Clk);
                wr_en = 1'b0;
                break;
            end
            prev = step_idx;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL wf_fetch_seen: got timeout, expected step 1 fetch"); end
        vectors++; if (note_change !== 1'b1 || note_code !== 8'h22) begin miscompares++; $display("FAIL wf_old_data: got nc %b note %h, expected 1 22", note_change, note_code); end
        wait_nc(1, ok);
        vectors++; if (!ok || note_code !== 8'h55) begin miscompares++; $display("FAIL wf_new_data: got ok %b note %h, expected 1 55", ok, note_code); end
        stop = 1'b1;
        @(negedge Clk);
        stop = 1'b0; loop_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        write_step(0, 0, 0, 8'h66);
        write_step(1, 0, 0, 8'h77);
        last_step = 4'd1; loop_en = 1'b0;
        pulse_play();
        wait_nc(1, ok);
        vectors++; if (!ok || note_code !== 8'h77) begin miscompares++; $display("FAIL rm_pre: got ok %b note %h, expected 1 77", ok, note_code); end
        repeat (3) @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        vectors++; if ({count_inc, note_change, gate, busy, done} !== 5'b0) begin miscompares++; $display("FAIL rm_ctrl: got %b, expected 00000", {count_inc, note_change, gate, busy, done}); end
        vectors++; if (note_code !== 8'h00 || step_idx !== 4'h0) begin miscompares++; $display("FAIL rm_data: got note %h idx %0d, expected 00 0", note_code, step_idx); end
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        pulse_play();
        wait_nc(0, ok);
        vectors++; if (!ok || note_code !== 8'h00) begin miscompares++; $display("FAIL rm_mem0: got ok %b note %h, expected 1 00", ok, note_code); end
        wait_nc(1, ok);
        vectors++; if (!ok || note_code !== 8'h00) begin miscompares++; $display("FAIL rm_mem1: got ok %b note %h, expected 1 00", ok, note_code); end
        stop = 1'b1;
        @(negedge Clk);
        stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_len_rest();
        test_loop();
        test_stop_play();
        test_write_fetch();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
